// File: rtl/ps2_cmd_sequencer.sv
`timescale 1ns/1ps
// PS/2 host command sequencer: sends a command byte plus an optional argument,
// checks each ACK/RESEND response, retries, times out and reports one status.
//
//   state    | meaning
//   ---------+----------------------------------------------------
//   IDLE     | ready for a command, cmd_ready high
//   LOAD     | present current byte on tx_data, clear retry count
//   START    | wait for transmitter idle, pulse tx_start
//   WAIT_TX  | wait for end of the transmitter frame
//   WAIT_RSP | wait for device response, timeout counter running
//   NEXT     | advance to the argument byte or finish
//   FIN_OK   | done + ack_ok pulse
//   FIN_ERR  | done + err pulse
module ps2_cmd_sequencer #(
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter int         MAX_RETRY      = 3,
  parameter logic [7:0] ACK_BYTE       = 8'hFA,
  parameter logic [7:0] RESEND_BYTE    = 8'hFE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       arg_en,
  input  logic [7:0] arg_byte,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       tx_done,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       done,
  output logic       ack_ok,
  output logic       err,
  output logic [1:0] err_code,
  output logic [3:0] debug_state
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);

  localparam logic [1:0] ERR_RETRY   = 2'b01;
  localparam logic [1:0] ERR_UNEXP   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_START    = 4'd2,
    S_WAIT_TX  = 4'd3,
    S_WAIT_RSP = 4'd4,
    S_NEXT     = 4'd5,
    S_FIN_OK   = 4'd6,
    S_FIN_ERR  = 4'd7
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    cmd_q, arg_q;
  logic          arg_en_q;
  logic          capture;
  logic          idx, idx_nx;
  logic [2:0]    retry, retry_nx;
  logic [TW-1:0] tmo, tmo_nx;
  logic [1:0]    err_code_nx;
  logic [7:0]    tx_data_nx;
  logic          tx_start_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    capture     = 1'b0;
    idx_nx      = idx;
    retry_nx    = retry;
    tmo_nx      = tmo;
    err_code_nx = err_code;
    tx_data_nx  = tx_data;
    tx_start_nx = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          capture     = 1'b1;
          err_code_nx = 2'b00;
          idx_nx      = 1'b0;
          state_nx    = S_LOAD;
        end
      end

      S_LOAD: begin
        tx_data_nx = idx ? arg_q : cmd_q;
        retry_nx   = 3'd0;
        state_nx   = S_START;
      end

      S_START: begin
        if (!tx_busy) begin
          tx_start_nx = 1'b1;
          state_nx    = S_WAIT_TX;
        end
      end

      S_WAIT_TX: begin
        if (tx_done) begin
          tmo_nx   = TMO_LOAD;
          state_nx = S_WAIT_RSP;
        end
      end

      S_WAIT_RSP: begin
        // A response arriving on the terminal-count cycle still counts.
        if (rx_valid) begin
          if (rx_data == ACK_BYTE) begin
            state_nx = S_NEXT;
          end else if (rx_data == RESEND_BYTE) begin
            if (retry < RETRY_MAX) begin
              retry_nx = retry + 3'd1;
              state_nx = S_START;
            end else begin
              err_code_nx = ERR_RETRY;
              state_nx    = S_FIN_ERR;
            end
          end else begin
            err_code_nx = ERR_UNEXP;
            state_nx    = S_FIN_ERR;
          end
        end else if (tmo == '0) begin
          err_code_nx = ERR_TIMEOUT;
          state_nx    = S_FIN_ERR;
        end else begin
          tmo_nx = tmo - 1'b1;
        end
      end

      S_NEXT: begin
        if (!idx && arg_en_q) begin
          idx_nx   = 1'b1;
          state_nx = S_LOAD;
        end else begin
          state_nx = S_FIN_OK;
        end
      end

      S_FIN_OK:  state_nx = S_IDLE;
      S_FIN_ERR: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q    <= 8'h00;
      arg_q    <= 8'h00;
      arg_en_q <= 1'b0;
      idx      <= 1'b0;
      retry    <= 3'd0;
      tmo      <= '0;
      err_code <= 2'b00;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      done     <= 1'b0;
      ack_ok   <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (capture) begin
        cmd_q    <= cmd_byte;
        arg_q    <= arg_byte;
        arg_en_q <= arg_en;
      end
      idx      <= idx_nx;
      retry    <= retry_nx;
      tmo      <= tmo_nx;
      err_code <= err_code_nx;
      tx_data  <= tx_data_nx;
      tx_start <= tx_start_nx;
      // Status pulses are registered so they coincide with the FIN_* cycle.
      done     <= (state_nx == S_FIN_OK) || (state_nx == S_FIN_ERR);
      ack_ok   <= (state_nx == S_FIN_OK);
      err      <= (state_nx == S_FIN_ERR);
    end
  end

  assign cmd_ready   = (state == S_IDLE);
  assign debug_state = state;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
`timescale 1ns/1ps
// Bench for ps2_cmd_sequencer: a transmitter/device model answers each frame from
// a response queue; transmitted bytes and completion status are scoreboarded.
module tb_ps2_cmd_sequencer;
  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_byte = 8'h00;
  logic       arg_en = 1'b0;
  logic [7:0] arg_byte = 8'h00;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       done, ack_ok, err;
  logic [1:0] err_code;
  logic [3:0] debug_state;

  logic model_busy = 1'b0;
  logic ext_busy   = 1'b0;
  assign tx_busy = model_busy | ext_busy;

  ps2_cmd_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY     (3),
    .ACK_BYTE      (8'hFA),
    .RESEND_BYTE   (8'hFE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_byte   (cmd_byte),
    .arg_en     (arg_en),
    .arg_byte   (arg_byte),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .done       (done),
    .ack_ok     (ack_ok),
    .err        (err),
    .err_code   (err_code),
    .debug_state(debug_state)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard queues
  logic [7:0] exp_tx[$];
  logic [3:0] exp_done[$];   // {ack_ok, err, err_code}
  logic [8:0] rsp_byte[$];   // bit 8 set = device stays silent
  int         rsp_dly[$];

  int   acc_cyc = 0;
  int   exp_start_cyc = 0;
  logic first_tx_pending = 1'b0;
  int   td_cyc = 0;
  int   last_rx_cyc = 0;
  int   exp_done_lat = -1;
  logic chk_tmo = 1'b0;
  int   done_cnt = 0;

  task automatic push_rsp(input logic [7:0] b, input int d);
    rsp_byte.push_back({1'b0, b});
    rsp_dly.push_back(d);
  endtask

  task automatic push_silent();
    rsp_byte.push_back(9'h100);
    rsp_dly.push_back(0);
  endtask

  // Transmitter + device model
  logic [8:0] m_b;
  int         m_d;
  always begin
    @(negedge clk);
    if (rst_n && tx_start) begin
      model_busy = 1'b1;
      repeat (4) @(posedge clk);
      #1 tx_done = 1'b1;
      model_busy = 1'b0;
      td_cyc = cyc + 1;
      @(posedge clk);
      #1 tx_done = 1'b0;
      if (rsp_byte.size() != 0) begin
        m_b = rsp_byte.pop_front();
        m_d = rsp_dly.pop_front();
        if (!m_b[8]) begin
          repeat (m_d) @(posedge clk);
          #1 rx_valid = 1'b1;
          rx_data = m_b[7:0];
          last_rx_cyc = cyc + 1;
          @(posedge clk);
          #1 rx_valid = 1'b0;
        end
      end
    end
  end

  // Output monitor
  logic [3:0] e_done;
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        if (exp_tx.size() == 0) check("tx_spurious", {31'b0, tx_start}, 32'd0);
        else check("tx_data", tx_data, exp_tx.pop_front());
        if (first_tx_pending) begin
          check("lat_start", cyc, exp_start_cyc);
          first_tx_pending = 1'b0;
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          check("done_spurious", {31'b0, done}, 32'd0);
        end else begin
          e_done = exp_done.pop_front();
          check("done_ack_ok", ack_ok, e_done[3]);
          check("done_err", err, e_done[2]);
          check("done_err_code", err_code, e_done[1:0]);
        end
        if (exp_done_lat >= 0) check("lat_done", cyc - last_rx_cyc, exp_done_lat);
        if (chk_tmo) check("lat_timeout", cyc - td_cyc, TMO);
      end
    end
  end

  task automatic send_cmd(input logic [7:0] c, input logic ae, input logic [7:0] a);
    int guard = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_byte  = c;
    arg_en    = ae;
    arg_byte  = a;
    @(negedge clk);
    while (!cmd_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    acc_cyc = cyc + 1;
    exp_start_cyc = acc_cyc + 2;
    first_tx_pending = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_byte  = 8'h00;
    arg_en    = 1'b0;
    arg_byte  = 8'h00;
    @(negedge clk);
    check("accept_ready_drop", cmd_ready, 1'b0);
    check("accept_code_clr", err_code, 2'b00);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, done_cnt - start, 1);
  endtask

  task automatic finish_scn(input logic [1:0] code);
    repeat (3) @(negedge clk);
    check("tx_left", exp_tx.size(), 0);
    check("done_left", exp_done.size(), 0);
    check("idle_ready", cmd_ready, 1'b1);
    check("code_hold", err_code, code);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dc0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_ack_ok", ack_ok, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_code", err_code, 2'b00);
    check("rst_debug_state", debug_state, 4'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single 0xFF; transmitter held busy first so START must wait
    ext_busy = 1'b1;
    exp_tx.push_back(8'hFF);
    push_rsp(8'hFA, 3);
    exp_done.push_back(4'b1000);
    exp_done_lat = 1;
    chk_tmo = 1'b0;
    send_cmd(8'hFF, 1'b0, 8'h00);
    repeat (8) @(posedge clk);
    #1 ext_busy = 1'b0;
    exp_start_cyc = cyc + 1;
    wait_done("s1_done", 300);
    finish_scn(2'b00);

    // Set LEDs 0xED + 0x05
    exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h05);
    push_rsp(8'hFA, 3);
    push_rsp(8'hFA, 2);
    exp_done.push_back(4'b1000);
    send_cmd(8'hED, 1'b1, 8'h05);
    wait_done("s2_done", 400);
    finish_scn(2'b00);

    // One RESEND then ACK
    exp_tx.push_back(8'hF4);
    exp_tx.push_back(8'hF4);
    push_rsp(8'hFE, 1);
    push_rsp(8'hFA, 4);
    exp_done.push_back(4'b1000);
    send_cmd(8'hF4, 1'b0, 8'h00);
    wait_done("s3_done", 400);
    finish_scn(2'b00);

    // Retries exhausted: four RESENDs
    for (int i = 0; i < 4; i++) begin
      exp_tx.push_back(8'hF4);
      push_rsp(8'hFE, 2);
    end
    exp_done.push_back(4'b0101);
    exp_done_lat = 0;
    send_cmd(8'hF4, 1'b0, 8'h00);
    wait_done("s4_done", 600);
    finish_scn(2'b01);

    // Timeout, no response
    exp_tx.push_back(8'hF2);
    push_silent();
    exp_done.push_back(4'b0111);
    exp_done_lat = -1;
    chk_tmo = 1'b1;
    send_cmd(8'hF2, 1'b0, 8'h00);
    wait_done("s5_done", 400);
    finish_scn(2'b11);
    chk_tmo = 1'b0;

    // ACK on the expiry cycle wins over timeout
    exp_tx.push_back(8'hF2);
    push_rsp(8'hFA, TMO - 1);
    exp_done.push_back(4'b1000);
    exp_done_lat = 1;
    send_cmd(8'hF2, 1'b0, 8'h00);
    wait_done("s6_done", 400);
    finish_scn(2'b00);

    // Unexpected response byte
    exp_tx.push_back(8'hF5);
    push_rsp(8'hAA, 2);
    exp_done.push_back(4'b0110);
    exp_done_lat = 0;
    send_cmd(8'hF5, 1'b0, 8'h00);
    wait_done("s7_done", 400);
    finish_scn(2'b10);

    // Reset in WAIT_RSP during set-LEDs
    exp_tx.push_back(8'hED);
    push_rsp(8'hFA, 40);
    exp_done_lat = -1;
    dc0 = done_cnt;
    send_cmd(8'hED, 1'b1, 8'h05);
    n = 0;
    while (debug_state != 4'd4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("s8_reach_wait_rsp", debug_state, 4'd4);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("s8_rst_cmd_ready", cmd_ready, 1'b1);
    check("s8_rst_tx_start", tx_start, 1'b0);
    check("s8_rst_tx_data", tx_data, 8'h00);
    check("s8_rst_done", done, 1'b0);
    check("s8_rst_ack_ok", ack_ok, 1'b0);
    check("s8_rst_err", err, 1'b0);
    check("s8_rst_err_code", err_code, 2'b00);
    check("s8_rst_debug_state", debug_state, 4'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("s8_tx_left", exp_tx.size(), 0);
    exp_tx.delete();
    repeat (60) @(negedge clk);
    check("s8_no_done", done_cnt - dc0, 0);
    check("s8_idle_ready", cmd_ready, 1'b1);
    check("s8_idle_state", debug_state, 4'd0);

    // Recovery after reset
    exp_tx.push_back(8'hFF);
    push_rsp(8'hFA, 3);
    exp_done.push_back(4'b1000);
    exp_done_lat = 1;
    send_cmd(8'hFF, 1'b0, 8'h00);
    wait_done("s9_done", 300);
    finish_scn(2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_sequencer.md
Name: ps2_cmd_sequencer

Overview:
Host-side command sequencer that sits directly upstream of the PS/2 host transmitter and downstream of the PS/2 receiver. It accepts a command byte with an optional argument byte (e.g. 0xED set-LEDs followed by its LED mask). It drives the transmitter one byte at a time and checks each device response for ACK (0xFA) or RESEND (0xFE). It retries on RESEND, enforces a response timeout and reports a single completion status per command.

Parameters:
TIMEOUT_CYCLES, 500000, clk cycles to wait for a response after tx_done (20 ms at 25 MHz); counter width $clog2(TIMEOUT_CYCLES+1)
MAX_RETRY, 3, number of RESENDs tolerated per byte before an error is flagged (1..7)
ACK_BYTE, 8'hFA, acknowledge code
RESEND_BYTE, 8'hFE, resend request code

Ports:
clk  input  1  system clock, 25 MHz nominal
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request; sampled only when cmd_ready=1
cmd_ready  output  1  high only in IDLE
cmd_byte  input  8  command byte, captured on accept
arg_en  input  1  1 = an argument byte follows the command; captured on accept
arg_byte  input  8  argument byte, captured on accept
tx_start  output  1  one-cycle pulse that launches the transmitter
tx_data  output  8  byte to transmit; stable from tx_start until tx_done
tx_busy  input  1  transmitter busy
tx_done  input  1  one-cycle pulse at the end of the transmitter frame (line ACK bit seen)
rx_valid  input  1  one-cycle pulse when the receiver has a byte
rx_data  input  8  received byte, valid with rx_valid
done  output  1  one-cycle completion pulse
ack_ok  output  1  with done: the whole sequence was acknowledged
err  output  1  with done: the sequence failed
err_code  output  2  01 retries exhausted, 10 unexpected response byte, 11 timeout; holds until the next accept
debug_state  output  4  current state encoding

Behaviour:
- Reset (async, rst_n=0): state IDLE; cmd_ready=1, tx_start=0, tx_data=0, done=0, ack_ok=0, err=0, err_code=00, debug_state=0; retry and timeout counters cleared. Reset mid-sequence aborts immediately; no done pulse is issued.
- State encoding: IDLE=0, LOAD=1, START=2, WAIT_TX=3, WAIT_RSP=4, NEXT=5, FIN_OK=6, FIN_ERR=7.
- IDLE: on cmd_valid&cmd_ready, capture cmd_byte, arg_en and arg_byte; clear err_code; select byte index 0; go to LOAD. cmd_ready drops on the next edge.
- LOAD: tx_data <= current byte (index 0 = cmd, index 1 = arg); clear the retry count on first entry per byte; go to START.
- START: wait for tx_busy=0, then pulse tx_start for exactly 1 cycle and go to WAIT_TX. tx_start is never asserted while tx_busy=1.
- WAIT_TX: on tx_done, clear the timeout counter and go to WAIT_RSP. rx_valid in this state is ignored.
- WAIT_RSP: counter increments each cycle.
  - rx_valid with ACK_BYTE -> NEXT.
  - rx_valid with RESEND_BYTE -> if retry < MAX_RETRY: retry++ and go to START (same tx_data); else err_code=01 and go to FIN_ERR.
  - rx_valid with any other byte -> err_code=10, FIN_ERR.
  - Counter reaching TIMEOUT_CYCLES with no rx_valid -> err_code=11, FIN_ERR.
  - If rx_valid and timeout expiry fall in the same cycle, rx_valid wins.
- NEXT: if index=0 and arg_en=1, set index=1 and go to LOAD; else go to FIN_OK.
- FIN_OK: done=1 and ack_ok=1 for 1 cycle, then IDLE. FIN_ERR: done=1 and err=1 for 1 cycle, then IDLE.
- rx_valid in IDLE, LOAD, START, NEXT or FIN_* is dropped; it is not buffered.
- cmd_valid while busy is ignored; the upstream holds it until cmd_ready.
- Latency: accept to tx_start = 3 cycles when tx_busy=0. Final ACK rx_valid to done = 2 cycles.

Test Plan:
- Single command 0xFF, arg_en=0: tx model tx_done then rx 0xFA -> exactly one tx_start with tx_data=FF; done and ack_ok pulse; err_code=00.
- Set LEDs: cmd 0xED, arg 0x05, both ACKed with 0xFA -> two tx_start pulses with tx_data ED then 05; one done with ack_ok=1.
- Resend: the first response to 0xF4 is 0xFE, the second is 0xFA -> two tx_start pulses, both with F4; ack_ok=1.
- Retry exhaustion, MAX_RETRY=3: four 0xFE responses -> four tx_start pulses; done with err=1 and err_code=01.
- Timeout with TIMEOUT_CYCLES=100 and no rx -> done with err=1 exactly 100 cycles after tx_done, err_code=11. In a second run, rx_valid with 0xFA on the expiry cycle -> ack_ok=1.
- Response 0xAA -> err_code=10. Repeat the set-LEDs scenario with rst_n pulsed low in WAIT_RSP -> all outputs take reset values at once, no done pulse, and cmd_ready=1.
